alu_seq: RTL and testbench
==========================

# alu_seq

Accumulator-based sequencer that drives the team's combinational `alu` block from the initiator side. It accepts one operation per command over a valid/ready handshake and presents the accumulator and operand on `bus_a`/`bus_b` with the matching `alu_sel`. It captures `alu_out` back into the accumulator and returns the updated accumulator plus flags over a second valid/ready handshake. It sits between a command source (test sequencer or control FSM) and one `alu` instance.

## Interface

Parameters:
- `WIDTH`, default 8: data width, signed two's complement; must match the attached `alu`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: sequencer can accept a command.
- `cmd_op`  in  3: opcode (see Operation).
- `cmd_data`  in  WIDTH: signed operand.
- `bus_a`  out  WIDTH: to `alu`; always the accumulator.
- `bus_b`  out  WIDTH: to `alu`; latched operand.
- `alu_sel`  out  3: to `alu`.
- `alu_out`  in  WIDTH: from `alu`.
- `res_valid`  out  1: response present.
- `res_ready`  in  1: consumer accepts response.
- `res_data`  out  WIDTH: accumulator after the operation.
- `res_zero`  out  1: `res_data == 0`.
- `res_neg`  out  1: `res_data` MSB set.
- `res_err`  out  1: illegal opcode.
- `res_ovf`  out  1: saturation occurred (see Configuration).

## Operation

Opcodes, with `alu_sel` driven in EXEC and the accumulator update:
- `000` LOAD: `alu_sel` 000; acc = `cmd_data`, taken from the latched operand, not from `alu_out`.
- `001` ADD: `alu_sel` 001; acc = `alu_out`.
- `010` SUB: `alu_sel` 010; acc = `alu_out`.
- `011` MUL: `alu_sel` 011; acc = `alu_out`, the low WIDTH bits.
- `100` HALF: `alu_sel` 100; acc = `alu_out`, which truncates toward zero (−3 → −1).
- `101` READ: `alu_sel` 000; acc unchanged; returns acc.
- `110` CLR: `alu_sel` 000; acc = 0.
- `111` illegal: `alu_sel` 000; acc unchanged; `res_err` = 1.

FSM states:
- IDLE: `cmd_ready` = 1. On `cmd_valid`, latch `cmd_op`/`cmd_data` and go to EXEC.
- EXEC: one cycle; drive the ALU from registers; at the clock edge write acc, `res_*`, and `res_valid` = 1, then go to RESP.
- RESP: hold all `res_*` stable while `res_valid` = 1. On `res_ready`, clear `res_valid` and go to IDLE.

Outputs and flags:
- In IDLE and RESP, `alu_sel` = 000 and `bus_b` holds its last latched value.
- `res_zero` and `res_neg` are computed from the final accumulator value, after saturation.

## Timing

- `cmd_ready` = (state == IDLE) && !`rst`, combinational.
- A command handshakes in cycle N; EXEC is cycle N+1; `res_valid` rises in cycle N+2. Minimum command-to-command spacing is 3 cycles. There is no overlap: `cmd_ready` stays 0 from EXEC until the response handshake completes.
- `res_ready` may be high before `res_valid`; the response then completes in the first cycle `res_valid` is high (N+2), and `cmd_ready` is 1 at N+3.
- Backpressure: `res_valid` and data hold indefinitely while `res_ready` = 0.
- Reset, sampled at any edge in any state: state = IDLE, acc = 0, latched operand = 0, `alu_sel` = 000, `res_valid`/`res_data`/`res_zero`/`res_neg`/`res_err`/`res_ovf` = 0. An in-flight command is discarded with no response. `res_zero` resets to 0, not 1.
- Arithmetic wraps modulo 2^WIDTH unless saturation is compiled in.

## Configuration

- `ALU_SEQ_SAT_EN` defined:
  - ADD overflow (operands same sign, result sign differs) clamps acc to +2^(WIDTH−1)−1 or −2^(WIDTH−1) by operand sign. SUB overflow (operands differ in sign, result sign ≠ `bus_a` sign) clamps the same way.
  - `res_ovf` = 1 on any clamp.
  - MUL and HALF are never clamped.
- Undefined: acc takes the wrapped `alu_out`; `res_ovf` tied 0; no overflow logic synthesised.

## Test plan

Bench instantiates `alu_seq` with `WIDTH` = 8 wired to an 8-bit `alu`.

- Reset then LOAD 5, ADD 3 → responses 5 then 8; `res_zero` = 0, `res_neg` = 0; `res_valid` exactly 2 cycles after each command handshake.
- LOAD 4, SUB 4 → `res_data` 0, `res_zero` 1. Then SUB 1 → `res_data` −1 (0xFF), `res_neg` 1.
- LOAD −3, HALF → `res_data` −1. Then LOAD 20, MUL 13 → `res_data` 4 (260 mod 256).
- LOAD 100, ADD 100:
  - without `ALU_SEQ_SAT_EN` → `res_data` −56, `res_ovf` 0;
  - with it → `res_data` 127, `res_ovf` 1.
  - With it, LOAD −100, SUB 100 → −128, `res_ovf` 1.
- Opcode 111 after LOAD 7 → `res_err` 1, `res_data` 7. `res_ready` held low 5 cycles → `res_*` stable and `cmd_ready` 0 throughout.
- Assert `rst` during EXEC of ADD → no response, acc 0, `cmd_ready` 1 the cycle after `rst` drops. Then READ → `res_data` 0.

Source files
------------

// File: rtl/alu_seq.sv
// Accumulator sequencer driving a combinational alu: one command in, one response out.
// Optional saturation of ADD/SUB results is compiled in with `define ALU_SEQ_SAT_EN.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] bus_a,
  output logic [WIDTH-1:0] bus_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_neg,
  output logic             res_err,
  output logic             res_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_HALF = 3'b100;
  localparam logic [2:0] OP_READ = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             neg;
    logic             err;
    logic             ovf;
  } res_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  res_t             res_q, res_d;
  logic             res_valid_q, res_valid_d;

  logic [WIDTH-1:0] acc_wrap, acc_next;
  logic             ovf_hit;

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_LOAD;
      opnd_q      <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator update; LOAD bypasses the alu and uses the latched operand
  always_comb begin
    acc_wrap = acc_q;
    case (op_q)
      OP_LOAD: acc_wrap = opnd_q;
      OP_ADD,
      OP_SUB,
      OP_MUL,
      OP_HALF: acc_wrap = alu_out;
      OP_READ: acc_wrap = acc_q;
      OP_CLR:  acc_wrap = '0;
      default: acc_wrap = acc_q;
    endcase
  end

`ifdef ALU_SEQ_SAT_EN
  logic add_ovf, sub_ovf;
  always_comb begin
    add_ovf  = (op_q == OP_ADD) && (acc_q[WIDTH-1] == opnd_q[WIDTH-1]) &&
               (alu_out[WIDTH-1] != acc_q[WIDTH-1]);
    sub_ovf  = (op_q == OP_SUB) && (acc_q[WIDTH-1] != opnd_q[WIDTH-1]) &&
               (alu_out[WIDTH-1] != acc_q[WIDTH-1]);
    ovf_hit  = add_ovf || sub_ovf;
    // On overflow the true result has the sign of bus_a in both cases
    acc_next = ovf_hit ? (acc_q[WIDTH-1] ? ACC_MIN : ACC_MAX) : acc_wrap;
  end
`else
  always_comb begin
    ovf_hit  = 1'b0;
    acc_next = acc_wrap;
  end
`endif

  // Command capture, accumulator write-back and response register
  always_comb begin
    op_d        = op_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          opnd_d = cmd_data;
        end
      end
      S_EXEC: begin
        acc_d       = acc_next;
        res_d.data  = acc_next;
        res_d.zero  = (acc_next == '0);
        res_d.neg   = acc_next[WIDTH-1];
        res_d.err   = (op_q == OP_ILL);
        res_d.ovf   = ovf_hit;
        res_valid_d = 1'b1;
      end
      S_RESP: begin
        if (res_ready) res_valid_d = 1'b0;
      end
      default: res_valid_d = 1'b0;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && !rst;
    alu_sel   = 3'b000;
    if (state_q == S_EXEC) begin
      case (op_q)
        OP_ADD:  alu_sel = 3'b001;
        OP_SUB:  alu_sel = 3'b010;
        OP_MUL:  alu_sel = 3'b011;
        OP_HALF: alu_sel = 3'b100;
        default: alu_sel = 3'b000;
      endcase
    end
    bus_a     = acc_q;
    bus_b     = opnd_q;
    res_valid = res_valid_q;
    res_data  = res_q.data;
    res_zero  = res_q.zero;
    res_neg   = res_q.neg;
    res_err   = res_q.err;
    res_ovf   = res_q.ovf;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq with WIDTH=8 and a behavioural 8-bit alu.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'b000;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] bus_a, bus_b, alu_out;
  logic [2:0]   alu_sel;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         res_zero, res_neg, res_err, res_ovf;

  typedef struct packed {
    logic [W-1:0] d;
    logic         z, n, e, o;
  } exp_t;

  exp_t sb[$];
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .bus_a(bus_a), .bus_b(bus_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_neg(res_neg), .res_err(res_err), .res_ovf(res_ovf)
  );

  // Reference alu
  always_comb begin
    logic signed [W-1:0] sa;
    logic        [2*W-1:0] prod;
    sa      = bus_a;
    prod    = bus_a * bus_b;
    alu_out = bus_a;
    case (alu_sel)
      3'b001:  alu_out = bus_a + bus_b;
      3'b010:  alu_out = bus_a - bus_b;
      3'b011:  alu_out = prod[W-1:0];
      3'b100:  alu_out = sa / 8'sd2;
      default: alu_out = bus_a;
    endcase
  end

  // Scoreboard: compare each response on the cycle it handshakes
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      vec_cnt++;
      if (sb.size() == 0) begin
        miss_cnt++;
        $display("FAIL unexpected_resp: got data=%h", res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({res_data, res_zero, res_neg, res_err, res_ovf} !== {e.d, e.z, e.n, e.e, e.o}) begin
          miss_cnt++;
          $display("FAIL resp: got d=%h z=%b n=%b e=%b o=%b, want d=%h z=%b n=%b e=%b o=%b",
                   res_data, res_zero, res_neg, res_err, res_ovf, e.d, e.z, e.n, e.e, e.o);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drives one command; returns at posedge+1 of the handshake edge (EXEC cycle)
  task automatic send(input logic [2:0] op, input logic [W-1:0] d, input logic want_resp,
                      input logic [W-1:0] ed, input logic ee, input logic eo);
    bit ok = 0;
    if (want_resp) sb.push_back('{d: ed, z: (ed == '0), n: ed[W-1], e: ee, o: eo});
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      vec_cnt++; miss_cnt++;
      $display("FAIL cmd_timeout: cmd_ready=%b want 1", cmd_ready);
      if (want_resp) void'(sb.pop_back());
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && cmd_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (!ok) begin
      miss_cnt++;
      $display("FAIL drain_timeout: pending=%0d want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if ({cmd_ready, res_valid, res_data, res_zero, res_neg, res_err, res_ovf, alu_sel, bus_a, bus_b} !== '0) begin
      miss_cnt++;
      $display("FAIL reset_state: rdy=%b vld=%b d=%h z=%b n=%b e=%b o=%b sel=%h a=%h b=%h want all 0",
               cmd_ready, res_valid, res_data, res_zero, res_neg, res_err, res_ovf, alu_sel, bus_a, bus_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (cmd_ready !== 1'b1) begin
      miss_cnt++;
      $display("FAIL reset_release: cmd_ready=%b want 1", cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_add();
    logic [W-1:0] lat;
    send(3'b000, 8'd5, 1, 8'd5, 0, 0);
    @(negedge clk); lat[0] = res_valid;
    @(negedge clk); lat[1] = res_valid;
    vec_cnt++;
    if (lat[1:0] !== 2'b10) begin
      miss_cnt++;
      $display("FAIL load_latency: res_valid N+1,N+2=%b%b want 01", lat[0], lat[1]);
    end
    drain();
    send(3'b001, 8'd3, 1, 8'd8, 0, 0);
    @(negedge clk);
    vec_cnt++;
    if (alu_sel !== 3'b001 || bus_a !== 8'd5 || bus_b !== 8'd3) begin
      miss_cnt++;
      $display("FAIL add_exec_bus: sel=%h a=%h b=%h want 1 05 03", alu_sel, bus_a, bus_b);
    end
    @(negedge clk);
    vec_cnt++;
    if (res_valid !== 1'b1) begin
      miss_cnt++;
      $display("FAIL add_latency: res_valid=%b want 1", res_valid);
    end
    drain();
  endtask

  task automatic test_sub_flags();
    send(3'b000, 8'd4, 1, 8'd4, 0, 0);
    send(3'b010, 8'd4, 1, 8'd0, 0, 0);
    send(3'b010, 8'd1, 1, 8'hFF, 0, 0);
    drain();
  endtask

  task automatic test_half_mul();
    send(3'b000, 8'hFD, 1, 8'hFD, 0, 0);
    send(3'b100, 8'h00, 1, 8'hFF, 0, 0);
    send(3'b000, 8'd20, 1, 8'd20, 0, 0);
    send(3'b011, 8'd13, 1, 8'd4, 0, 0);
    send(3'b110, 8'd9, 1, 8'd0, 0, 0);
    drain();
  endtask

  task automatic test_overflow();
    send(3'b000, 8'd100, 1, 8'd100, 0, 0);
`ifdef ALU_SEQ_SAT_EN
    send(3'b001, 8'd100, 1, 8'h7F, 0, 1);
    send(3'b000, 8'h9C, 1, 8'h9C, 0, 0);
    send(3'b010, 8'd100, 1, 8'h80, 0, 1);
`else
    send(3'b001, 8'd100, 1, 8'hC8, 0, 0);
    send(3'b000, 8'h9C, 1, 8'h9C, 0, 0);
    send(3'b010, 8'd100, 1, 8'h38, 0, 0);
`endif
    drain();
  endtask

  task automatic test_err_backpressure();
    int bad = 0;
    send(3'b000, 8'd7, 1, 8'd7, 0, 0);
    drain();
    res_ready = 1'b0;
    send(3'b111, 8'h55, 1, 8'd7, 1, 0);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      vec_cnt++;
      if (res_valid !== 1'b1 || res_data !== 8'd7 || res_err !== 1'b1 || cmd_ready !== 1'b0) begin
        miss_cnt++; bad++;
        $display("FAIL hold: vld=%b d=%h err=%b rdy=%b want 1 07 1 0", res_valid, res_data, res_err, cmd_ready);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    drain();
    @(negedge clk);
    vec_cnt++;
    if (alu_sel !== 3'b000 || bus_b !== 8'h55 || bus_a !== 8'd7) begin
      miss_cnt++;
      $display("FAIL idle_bus: sel=%h a=%h b=%h want 0 07 55", alu_sel, bus_a, bus_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    send(3'b000, 8'd9, 1, 8'd9, 0, 0);
    drain();
    send(3'b001, 8'd1, 0, 8'd0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || bus_a !== 8'd0) begin
      miss_cnt++;
      $display("FAIL mid_reset: rdy=%b vld=%b acc=%h want 1 0 00", cmd_ready, res_valid, bus_a);
    end
    @(negedge clk);
    vec_cnt++;
    if (res_valid !== 1'b0) begin
      miss_cnt++;
      $display("FAIL mid_reset_noresp: res_valid=%b want 0", res_valid);
    end
    @(posedge clk); #1;
    send(3'b101, 8'd33, 1, 8'd0, 0, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_sub_flags();
    test_half_mul();
    test_overflow();
    test_err_backpressure();
    test_reset_midflight();
    vec_cnt++;
    if (sb.size() != 0) begin
      miss_cnt++;
      $display("FAIL leftover: pending=%0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
